// File: rtl/cla_seq_adder_32bit_pkg.sv
// Shared constants for the multi-cycle carry-lookahead adder: default geometry
// and FSM state encodings.
package cla_seq_adder_32bit_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int SLICE_DEF  = 4;
    localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Slice-index width; kept at least 1 so a single-slice build still elaborates.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_32bit_slice.sv
// Combinational carry-lookahead slice: generate/propagate per bit, carries
// resolved inside the slice, carry vector exposed for overflow detection.
module cla_slice_4bit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic [N-1:0] c
);

    logic [N-1:0] g;
    logic [N-1:0] p;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_gp
            assign g[gi] = a[gi] & b[gi];
            assign p[gi] = a[gi] | b[gi];
        end
    endgenerate

    // Walking a local carry avoids a combinational self-loop on c.
    always_comb begin
        logic cc;
        cc  = cin;
        sum = '0;
        c   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ cc;
            cc     = g[i] | (p[i] & cc);
            c[i]   = cc;
        end
    end

endmodule

// File: rtl/cla_seq_adder_32bit.sv
// Multi-cycle WIDTH-bit adder resolving one SLICE-bit lookahead slice per clock,
// LSB first, with the inter-slice carry held in a register.
module cla_seq_adder_32bit
    import cla_seq_adder_32bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = idx_width(NSLICE);

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] a_sl [NSLICE];
    logic [SLICE-1:0] b_sl [NSLICE];
    logic [SLICE-1:0] slice_sum;
    logic [SLICE-1:0] slice_c;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_split
            assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
            assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
        end
    endgenerate

    cla_slice_4bit #(
        .N(SLICE)
    ) u_slice (
        .a   (a_sl[idx_q]),
        .b   (b_sl[idx_q]),
        .cin (carry_q),
        .sum (slice_sum),
        .c   (slice_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        acc_d[i*SLICE +: SLICE] = slice_sum;
                    end
                end
                carry_d = slice_c[SLICE-1];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NSLICE - 1)) begin
                    // Carry into the MSB is the second-to-last carry of the top slice.
                    sum_d   = acc_d;
                    cout_d  = slice_c[SLICE-1];
                    ovf_d   = slice_c[SLICE-1] ^ slice_c[SLICE-2];
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation, giving back-to-back issue.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder_32bit.sv
// Directed bench for the multi-cycle CLA adder: reset, arithmetic corners,
// start-while-busy, mid-run reset and back-to-back issue.
module tb_cla_seq_adder_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_adder_32bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs so a
    // late recapture would corrupt the result.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        a        = av;
        b        = bv;
        carry_in = cv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
        carry_in = 1'b1;
    endtask

    // Cycles from the accepting edge until done is seen; -1 if it never comes.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cycles++;
            tick();
            cycles++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, carry_out, overflow} !== 4'b0000 || sum !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, carry_out, overflow);
        end
        $display("reset: busy=%b done=%b sum=%h", busy, done, sum);
        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; a = 32'h1; b = 32'h1;
        tick();
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: busy=%b, want 0", busy);
        end
        tick();
    endtask

    task automatic test_vector(input string name, input logic [31:0] av, input logic [31:0] bv,
                               input logic cv, input logic [31:0] es, input logic ec,
                               input logic eo);
        int cyc, bcyc;
        issue(av, bv, cv);
        wait_done(cyc, bcyc);
        $display("%s: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b latency=%0d",
                 name, av, bv, cv, sum, carry_out, overflow, cyc);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, want 8", name, cyc);
        end
        n_checks++;
        if (sum !== es || carry_out !== ec || overflow !== eo) begin
            n_fail++;
            $display("FAIL %s_result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, sum, carry_out, overflow, es, ec, eo);
        end
        n_checks++;
        if (busy !== 1'b0 || bcyc !== 8) begin
            n_fail++;
            $display("FAIL %s_busy: busy=%b busy_cycles=%0d, want 0 and 8", name, busy, bcyc);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || sum !== es) begin
            n_fail++;
            $display("FAIL %s_hold: done=%b sum=%h, want done=0 sum=%h", name, done, sum, es);
        end
    endtask

    task automatic test_start_while_busy();
        int done_cnt, busy_cnt;
        logic [31:0] got;
        done_cnt = 0; busy_cnt = 0; got = '0;
        issue(32'h1234_5678, 32'h8765_4321, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
            end
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; got = sum; end
            tick();
            start = 1'b0;
        end
        $display("start_while_busy: dones=%0d busy_cycles=%0d sum=%h", done_cnt, busy_cnt, got);
        n_checks++;
        if (done_cnt !== 1 || busy_cnt !== 8) begin
            n_fail++;
            $display("FAIL busy_ignore_count: dones=%0d busy=%0d, want 1 and 8", done_cnt, busy_cnt);
        end
        n_checks++;
        if (got !== 32'h9999_999A) begin
            n_fail++;
            $display("FAIL busy_ignore_result: sum=%h, want 9999999a", got);
        end
    endtask

    task automatic test_mid_run_reset();
        int dones;
        dones = 0;
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("mid_run_reset: busy=%b done=%b sum=%h cout=%b ovf=%b",
                 busy, done, sum, carry_out, overflow);
        n_checks++;
        if ({busy, done, carry_out, overflow} !== 4'b0000 || sum !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, carry_out, overflow);
        end
        for (int i = 0; i < 10; i++) begin
            if (done || busy) dones++;
            tick();
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d busy/done cycles after abort, want 0", dones);
        end
        test_vector("after_abort", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        issue(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(cyc, bcyc);
        n_checks++;
        if (cyc !== 8 || sum !== 32'h0 || carry_out !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_op1: latency=%0d sum=%h cout=%b ovf=%b, want 8 00000000 1 1",
                     cyc, sum, carry_out, overflow);
        end
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || sum !== 32'h0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold: busy=%b sum=%h ovf=%b, want busy=1 sum=00000000 ovf=1",
                     busy, sum, overflow);
        end
        wait_done(cyc, bcyc);
        $display("back_to_back: op2 sum=%h cout=%b ovf=%b spacing=%0d",
                 sum, carry_out, overflow, cyc + 1);
        n_checks++;
        if (cyc + 1 !== 9) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d cycles between dones, want 9", cyc + 1);
        end
        n_checks++;
        if (sum !== 32'hFFFF_FFFF || carry_out !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_op2: sum=%h cout=%b ovf=%b, want ffffffff 1 0",
                     sum, carry_out, overflow);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_vector("carry_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_vector("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_vector("mixed_cin",  32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0);
        test_vector("neg_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        test_start_while_busy();
        test_mid_run_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
